// File: rtl/store_packer.sv
// store_packer: MIPS store aligner with 2-entry buffer; STORE_ALIGN_CHECK_EN enables misaligned-store exceptions
module store_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    input  logic [1:0]  in_op,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        exc_ades,
    output logic [31:0] exc_addr
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} bufStateT;
    bufStateT state, stateNext;
    logic accept, misaligned, enq, deq;
    logic [29:0] headAddr, tailAddr;
    logic [31:0] headData, tailData, newData;
    logic [3:0] headBe, tailBe, newBe;
    assign in_ready = state != TWO;
    assign mem_valid = state != EMPTY;
    assign accept = in_valid && in_ready;
    assign deq = mem_valid && mem_ready;
    assign enq = accept && in_op != 2'b00 && !misaligned;
    assign newBe = in_op == 2'b01 ? 4'b0001 << in_addr[1:0] :
                   in_op == 2'b10 ? (in_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign newData = in_op == 2'b01 ? {4{in_data[7:0]}} :
                     in_op == 2'b10 ? {2{in_data[15:0]}} : in_data;
    assign mem_addr = {headAddr, 2'b00};
    assign mem_wdata = headData;
    assign mem_be = headBe;
`ifdef STORE_ALIGN_CHECK_EN
    assign misaligned = (in_op == 2'b10 && in_addr[0]) || (in_op == 2'b11 && in_addr[1:0] != 2'b00);
    always_ff @(posedge clk) begin
        if (reset) begin
            exc_ades <= 1'b0;
            exc_addr <= '0;
        end else begin
            exc_ades <= accept && misaligned;
            if (accept && misaligned) exc_addr <= in_addr;
        end
    end
`else
    assign misaligned = 1'b0;
    assign exc_ades = 1'b0;
    assign exc_addr = '0;
`endif
    always_comb begin
        stateNext = state;
        stateNext = state == EMPTY ? (enq ? ONE : EMPTY) :
                    state == ONE   ? (enq && !deq ? TWO : (!enq && deq ? EMPTY : ONE)) :
                                     (deq ? ONE : TWO);
    end
    always_ff @(posedge clk) begin
        if (reset) state <= EMPTY;
        else state <= stateNext;
    end
    // New entries go to the head when it is free or leaving this cycle, else behind it
    always_ff @(posedge clk) begin
        if (reset) begin
            headAddr <= '0;
            headData <= '0;
            headBe   <= '0;
            tailAddr <= '0;
            tailData <= '0;
            tailBe   <= '0;
        end else begin
            if (enq && (state == EMPTY || (state == ONE && deq))) begin
                headAddr <= in_addr[31:2];
                headData <= newData;
                headBe   <= newBe;
            end else if (deq && state == TWO) begin
                headAddr <= tailAddr;
                headData <= tailData;
                headBe   <= tailBe;
            end
            if (enq && state == ONE && !deq) begin
                tailAddr <= in_addr[31:2];
                tailData <= newData;
                tailBe   <= newBe;
            end
        end
    end
endmodule

// File: tb/tb_store_packer.sv
// tb_store_packer: randomized and directed checks of store_packer against a queue-based reference model
module tb_store_packer;
    logic clk = 1'b0;
    logic reset, in_valid, in_ready, mem_valid, mem_ready, exc_ades;
    logic [31:0] in_addr, in_data, mem_addr, mem_wdata, exc_addr;
    logic [1:0] in_op;
    logic [3:0] mem_be;
    int checks = 0;
    int failures = 0;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } entryT;
    entryT q[$];
    logic expExc = 1'b0;
    logic [31:0] expExcAddr = '0;

    always #5 clk = ~clk;

    store_packer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .in_op(in_op),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .exc_ades(exc_ades), .exc_addr(exc_addr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic entryT pack(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] op);
        entryT e;
        int n, base;
        n = op == 2'd1 ? 1 : op == 2'd2 ? 2 : 4;
        base = int'(addr[1:0]) / n * n;
        e.addr = addr & 32'hFFFF_FFFC;
        e.be = '0;
        for (int i = 0; i < 4; i++) begin
            e.data[8*i +: 8] = data[8*(i % n) +: 8];
            if (i >= base && i < base + n) e.be[i] = 1'b1;
        end
        return e;
    endfunction

    function automatic logic misal(input logic [31:0] addr, input logic [1:0] op);
`ifdef STORE_ALIGN_CHECK_EN
        return (op == 2'd2 && addr % 2 != 0) || (op == 2'd3 && addr % 4 != 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic compare();
        check("mem_valid", 32'(mem_valid), 32'(q.size() != 0));
        check("in_ready", 32'(in_ready), 32'(q.size() < 2));
        if (q.size() != 0) begin
            check("mem_addr", mem_addr, q[0].addr);
            check("mem_wdata", mem_wdata, q[0].data);
            check("mem_be", 32'(mem_be), 32'(q[0].be));
        end
        check("exc_ades", 32'(exc_ades), 32'(expExc));
        if (expExc) check("exc_addr", exc_addr, expExcAddr);
    endtask

    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] op, input logic mr);
        logic acc, dq;
        compare();
        in_valid = v;
        in_addr = a;
        in_data = d;
        in_op = op;
        mem_ready = mr;
        acc = v && q.size() < 2;
        dq = q.size() != 0 && mr;
        if (dq) void'(q.pop_front());
        expExc = 1'b0;
        if (acc && op != 2'd0) begin
            if (misal(a, op)) begin
                expExc = 1'b1;
                expExcAddr = a;
            end else q.push_back(pack(a, d, op));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        reset = 1'b1;
        in_valid = 1'b0;
        in_op = 2'd0;
        mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        expExc = 1'b0;
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_exc_ades", 32'(exc_ades), 32'd0);
        check("rst_exc_addr", exc_addr, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_addr = '0;
        in_data = '0;
        in_op = 2'd0;
        mem_ready = 1'b0;
        doReset();
        cycle(1'b1, 32'h0000_1003, 32'h1234_56AB, 2'd1, 1'b1);
        check("sb_addr", mem_addr, 32'h0000_1000);
        check("sb_be", 32'(mem_be), 32'h8);
        check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        cycle(1'b0, 32'd0, 32'd0, 2'd0, 1'b1);
        check("sb_drained", 32'(mem_valid), 32'd0);
        cycle(1'b1, 32'h0000_2002, 32'hDEAD_BEEF, 2'd2, 1'b1);
        check("sh_be", 32'(mem_be), 32'hC);
        check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
        cycle(1'b1, 32'h0000_2004, 32'hCAFE_F00D, 2'd3, 1'b1);
        check("sw_be", 32'(mem_be), 32'hF);
        check("sw_wdata", mem_wdata, 32'hCAFE_F00D);
        cycle(1'b0, 32'd0, 32'd0, 2'd0, 1'b1);
        cycle(1'b1, 32'h0000_4000, 32'hAAAA_0001, 2'd3, 1'b0);
        cycle(1'b1, 32'h0000_4004, 32'hBBBB_0002, 2'd3, 1'b0);
        check("full_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h0000_4008, 32'hCCCC_0003, 2'd3, 1'b0);
        check("stall_head", mem_addr, 32'h0000_4000);
        cycle(1'b1, 32'h0000_4008, 32'hCCCC_0003, 2'd3, 1'b1);
        cycle(1'b1, 32'h0000_4008, 32'hCCCC_0003, 2'd3, 1'b1);
        cycle(1'b0, 32'd0, 32'd0, 2'd0, 1'b1);
        check("order_c", mem_wdata, 32'hCCCC_0003);
        cycle(1'b0, 32'd0, 32'd0, 2'd0, 1'b1);
        cycle(1'b1, 32'h0000_3002, 32'h1111_2222, 2'd3, 1'b1);
`ifdef STORE_ALIGN_CHECK_EN
        check("ades_pulse", 32'(exc_ades), 32'd1);
        check("ades_addr", exc_addr, 32'h0000_3002);
        check("ades_no_entry", 32'(mem_valid), 32'd0);
        cycle(1'b0, 32'd0, 32'd0, 2'd0, 1'b1);
        check("ades_one_cycle", 32'(exc_ades), 32'd0);
        cycle(1'b1, 32'h0000_6001, 32'd0, 2'd3, 1'b1);
        cycle(1'b1, 32'h0000_6003, 32'd0, 2'd2, 1'b1);
        check("ades_b2b_addr", exc_addr, 32'h0000_6003);
        cycle(1'b1, 32'h0000_5001, 32'd0, 2'd2, 1'b1);
        doReset();
`else
        check("noalign_addr", mem_addr, 32'h0000_3000);
        check("noalign_be", 32'(mem_be), 32'hF);
        cycle(1'b0, 32'd0, 32'd0, 2'd0, 1'b1);
`endif
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, $urandom, $urandom, 2'd1, 1'b1);
            check("stream_in_ready", 32'(in_ready), 32'd1);
            check("stream_valid", 32'(mem_valid), 32'd1);
        end
        cycle(1'b1, 32'h0000_7000, 32'h7, 2'd3, 1'b0);
        cycle(1'b1, 32'h0000_7004, 32'h8, 2'd3, 1'b0);
        check("fill_two", 32'(in_ready), 32'd0);
        doReset();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(99) == 0) doReset();
            else cycle($urandom_range(3) != 0, $urandom, $urandom, 2'($urandom_range(3)), $urandom_range(3) != 0);
        end
        compare();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
